// File: rtl/fifo_read_scheduler.sv
// fifo_read_scheduler: paces reads from pixel FIFO A then FIFO B into one RGB stream per line.
// Optional macro FIFO_EMPTY_GUARD_EN stalls a read slot while its FIFO is empty instead of flagging underrun.
module fifo_read_scheduler #(
    parameter int PACE_CYCLES = 6000,
    parameter int SEG_A_LEN   = 78,
    parameter int SEG_B_LEN   = 45
) (
    input  logic        clk_200MHz,
    input  logic        reset,
    input  logic        line_start,
    input  logic        frame_sync,
    input  logic        empty_a,
    input  logic        empty_b,
    input  logic [23:0] data_a,
    input  logic [23:0] data_b,
    output logic        rd_en_a,
    output logic        rd_en_b,
    output logic [23:0] rgb_data,
    output logic        rgb_valid,
    output logic        busy,
    output logic        line_done,
    output logic        overrun_err,
    output logic        underrun_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEG_A = 2'd1,
        SEG_B = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [15:0] PACE_LAST  = 16'(PACE_CYCLES - 1);
    localparam logic [7:0]  SEG_A_LAST = 8'(SEG_A_LEN - 1);
    localparam logic [7:0]  SEG_B_LAST = 8'(SEG_B_LEN - 1);

    state_t      state_r;
    logic [15:0] pace_cnt_r;
    logic [7:0]  word_cnt_r;
    logic [23:0] rgb_data_r;
    logic        rgb_valid_r;
    logic        overrun_err_r;
    logic        underrun_err_r;

    logic        in_seg_s;
    logic        target_empty_s;
    logic        seg_last_s;
    logic        slot_s;
    logic        slot_ready_s;
    logic        issue_s;
    logic        rd_en_a_s;
    logic        rd_en_b_s;
    logic        line_done_s;

    // Strobes must react to frame_sync/empty in the slot cycle itself, so they are decoded from registered state
    always_comb begin
        in_seg_s       = 1'b0;
        target_empty_s = 1'b0;
        seg_last_s     = 1'b0;
        case (state_r)
            SEG_A: begin
                in_seg_s       = 1'b1;
                target_empty_s = empty_a;
                seg_last_s     = (word_cnt_r == SEG_A_LAST);
            end
            SEG_B: begin
                in_seg_s       = 1'b1;
                target_empty_s = empty_b;
                seg_last_s     = (word_cnt_r == SEG_B_LAST);
            end
            default: begin
                in_seg_s       = 1'b0;
                target_empty_s = 1'b0;
                seg_last_s     = 1'b0;
            end
        endcase
        slot_s = in_seg_s && (pace_cnt_r == PACE_LAST);
`ifdef FIFO_EMPTY_GUARD_EN
        slot_ready_s = slot_s && !target_empty_s;
`else
        slot_ready_s = slot_s;
`endif
        issue_s     = slot_ready_s && !frame_sync && !reset;
        rd_en_a_s   = issue_s && (state_r == SEG_A);
        rd_en_b_s   = issue_s && (state_r == SEG_B);
        line_done_s = (state_r == DONE) && !frame_sync && !reset;
    end

    // Line sequencer, pace/word counters, pixel output register and sticky error flags
    always_ff @(posedge clk_200MHz) begin
        if (reset) begin
            state_r        <= IDLE;
            pace_cnt_r     <= 16'd0;
            word_cnt_r     <= 8'd0;
            rgb_data_r     <= 24'd0;
            rgb_valid_r    <= 1'b0;
            overrun_err_r  <= 1'b0;
            underrun_err_r <= 1'b0;
        end else begin
            if (line_start && (state_r != IDLE)) begin
                overrun_err_r <= 1'b1;
            end else begin
                overrun_err_r <= overrun_err_r;
            end
`ifndef FIFO_EMPTY_GUARD_EN
            if (issue_s && target_empty_s) begin
                underrun_err_r <= 1'b1;
            end else begin
                underrun_err_r <= underrun_err_r;
            end
`endif
            // A read issued just before an abort still delivers its word
            rgb_valid_r <= rd_en_a_s || rd_en_b_s;
            if (rd_en_a_s) begin
                rgb_data_r <= data_a;
            end else if (rd_en_b_s) begin
                rgb_data_r <= data_b;
            end else begin
                rgb_data_r <= rgb_data_r;
            end

            if (frame_sync) begin
                state_r    <= IDLE;
                pace_cnt_r <= 16'd0;
                word_cnt_r <= 8'd0;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (line_start) begin
                            state_r    <= SEG_A;
                            pace_cnt_r <= 16'd0;
                            word_cnt_r <= 8'd0;
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                    SEG_A, SEG_B: begin
                        if (issue_s) begin
                            pace_cnt_r <= 16'd0;
                            if (seg_last_s) begin
                                word_cnt_r <= 8'd0;
                                state_r    <= (state_r == SEG_A) ? SEG_B : DONE;
                            end else begin
                                word_cnt_r <= word_cnt_r + 8'd1;
                            end
                        end else if (!slot_s) begin
                            pace_cnt_r <= pace_cnt_r + 16'd1;
                        end else begin
                            // stalled slot: hold counters until the target FIFO has data
                            pace_cnt_r <= pace_cnt_r;
                        end
                    end
                    DONE: begin
                        state_r <= IDLE;
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

    assign rd_en_a      = rd_en_a_s;
    assign rd_en_b      = rd_en_b_s;
    assign rgb_data     = rgb_data_r;
    assign rgb_valid    = rgb_valid_r;
    assign busy         = in_seg_s;
    assign line_done    = line_done_s;
    assign overrun_err  = overrun_err_r;
    assign underrun_err = underrun_err_r;

endmodule

// Protocol properties of the scheduler outputs.
module fifo_read_scheduler_chk (
    input logic clk_200MHz,
    input logic reset,
    input logic rd_en_a,
    input logic rd_en_b,
    input logic rgb_valid,
    input logic busy,
    input logic line_done
);

    a_rd_exclusive: assert property (@(posedge clk_200MHz) !(rd_en_a && rd_en_b));

    a_valid_follows_read: assert property (@(posedge clk_200MHz) disable iff (reset)
        (rd_en_a || rd_en_b) |=> rgb_valid);

    a_done_single_pulse: assert property (@(posedge clk_200MHz) disable iff (reset)
        line_done |=> !line_done);

    a_done_not_busy: assert property (@(posedge clk_200MHz) !(line_done && busy));

endmodule

// File: tb/tb_fifo_read_scheduler.sv
// Randomized and directed bench for fifo_read_scheduler: per-cycle reference model plus rgb word scoreboard.
module tb_fifo_read_scheduler;

    localparam int P = 4;
    localparam int A = 3;
    localparam int B = 2;

    logic        clk_200MHz = 1'b0;
    logic        reset      = 1'b1;
    logic        line_start = 1'b0;
    logic        frame_sync = 1'b0;
    logic        empty_a    = 1'b0;
    logic        empty_b    = 1'b0;
    logic [23:0] data_a     = 24'd0;
    logic [23:0] data_b     = 24'd0;
    logic        rd_en_a, rd_en_b, rgb_valid, busy, line_done, overrun_err, underrun_err;
    logic [23:0] rgb_data;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int cyc0   = 0;

    // reference model: line progress expressed as reads completed and cycles left to the next slot
    bit m_active = 1'b0;
    bit m_done   = 1'b0;
    bit m_ovr    = 1'b0;
    bit m_und    = 1'b0;
    int m_n      = 0;
    int m_rem    = 0;

    logic [23:0] exp_q[$];
    bit          valid_exp_next = 1'b0;
    bit          valid_exp_cur  = 1'b0;
    bit          rst_next       = 1'b0;
    bit          rst_cur        = 1'b0;
    bit          mon_en         = 1'b0;
    logic [23:0] last_rgb       = 24'd0;
    logic [63:0] mask_a, mask_b, mask_done;

    always #5 clk_200MHz = ~clk_200MHz;

    fifo_read_scheduler #(.PACE_CYCLES(P), .SEG_A_LEN(A), .SEG_B_LEN(B)) dut (
        .clk_200MHz  (clk_200MHz),
        .reset       (reset),
        .line_start  (line_start),
        .frame_sync  (frame_sync),
        .empty_a     (empty_a),
        .empty_b     (empty_b),
        .data_a      (data_a),
        .data_b      (data_b),
        .rd_en_a     (rd_en_a),
        .rd_en_b     (rd_en_b),
        .rgb_data    (rgb_data),
        .rgb_valid   (rgb_valid),
        .busy        (busy),
        .line_done   (line_done),
        .overrun_err (overrun_err),
        .underrun_err(underrun_err)
    );

    fifo_read_scheduler_chk chk (
        .clk_200MHz(clk_200MHz),
        .reset     (reset),
        .rd_en_a   (rd_en_a),
        .rd_en_b   (rd_en_b),
        .rgb_valid (rgb_valid),
        .busy      (busy),
        .line_done (line_done)
    );

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk64(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // one clock cycle: drive inputs, compare strobes/flags against the model, then advance the model
    task automatic step(input logic ls, input logic fs, input logic ea, input logic eb, input logic rst);
        bit tgt_a, slot, empty_t, can, issue;
        int rel;
        @(posedge clk_200MHz);
        #1;
        line_start = ls;
        frame_sync = fs;
        empty_a    = ea;
        empty_b    = eb;
        reset      = rst;
        data_a     = 24'($urandom);
        data_b     = 24'($urandom);
        cyc++;
        valid_exp_cur = valid_exp_next;
        rst_cur       = rst_next;
        #1;
        tgt_a   = (m_n < A);
        slot    = m_active && (m_rem == 0);
        empty_t = tgt_a ? ea : eb;
`ifdef FIFO_EMPTY_GUARD_EN
        can = !empty_t;
`else
        can = 1'b1;
`endif
        issue = slot && can && !fs && !rst;
        chk1("rd_en_a", rd_en_a, issue && tgt_a);
        chk1("rd_en_b", rd_en_b, issue && !tgt_a);
        chk1("busy", busy, m_active);
        chk1("line_done", line_done, m_done && !fs && !rst);
        chk1("overrun_err", overrun_err, m_ovr);
        chk1("underrun_err", underrun_err, m_und);
        if (issue) exp_q.push_back(tgt_a ? data_a : data_b);
        rel = cyc - cyc0;
        if (rel >= 0 && rel < 64) begin
            if (rd_en_a === 1'b1)   mask_a    = mask_a    | (64'd1 << rel);
            if (rd_en_b === 1'b1)   mask_b    = mask_b    | (64'd1 << rel);
            if (line_done === 1'b1) mask_done = mask_done | (64'd1 << rel);
        end
        valid_exp_next = issue;
        rst_next       = rst;
        if (rst) begin
            m_active = 1'b0; m_done = 1'b0; m_ovr = 1'b0; m_und = 1'b0; m_n = 0; m_rem = 0;
        end else begin
            if (ls && (m_active || m_done)) m_ovr = 1'b1;
`ifndef FIFO_EMPTY_GUARD_EN
            if (issue && empty_t) m_und = 1'b1;
`endif
            if (fs) begin
                m_active = 1'b0;
                m_done   = 1'b0;
            end else if (m_done) begin
                m_done = 1'b0;
            end else if (m_active) begin
                if (issue) begin
                    m_n++;
                    m_rem = P - 1;
                    if (m_n == A + B) begin
                        m_active = 1'b0;
                        m_done   = 1'b1;
                    end
                end else if (!slot) begin
                    m_rem--;
                end
            end else if (ls) begin
                m_active = 1'b1;
                m_n      = 0;
                m_rem    = P - 1;
            end
        end
    endtask

    // one line started at relative cycle 0, with optional extra events; strobe timing checked as cycle masks
    task automatic run_line(input string nm, input int n_cyc, input int ls2_at, input int fs_at,
                            input int rst_at, input int ea_lo, input int ea_hi, input int eb_at,
                            input logic [63:0] exp_a, input logic [63:0] exp_b, input logic [63:0] exp_done);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        mask_a = 64'd0; mask_b = 64'd0; mask_done = 64'd0;
        cyc0 = cyc + 1;
        for (int r = 0; r < n_cyc; r++) begin
            step((r == 0) || (r == ls2_at), r == fs_at, (r >= ea_lo) && (r <= ea_hi), r == eb_at, r == rst_at);
        end
        chk64({nm, "_rd_a"}, mask_a, exp_a);
        chk64({nm, "_rd_b"}, mask_b, exp_b);
        chk64({nm, "_done"}, mask_done, exp_done);
    endtask

    // scoreboard monitor: one expected word per rgb_valid, otherwise rgb_data must hold
    initial begin
        logic [23:0] exp;
        forever begin
            @(negedge clk_200MHz);
            if (mon_en) begin
                if (rst_cur) last_rgb = 24'd0;
                checks++;
                if (rgb_valid !== valid_exp_cur) begin
                    errors++;
                    $display("FAIL rgb_valid: got %b expected %b (cycle %0d)", rgb_valid, valid_exp_cur, cyc);
                end
                if (rgb_valid === 1'b1) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL rgb_word: got %h expected none (cycle %0d)", rgb_data, cyc);
                    end else begin
                        exp = exp_q.pop_front();
                        if (rgb_data !== exp) begin
                            errors++;
                            $display("FAIL rgb_word: got %h expected %h (cycle %0d)", rgb_data, exp, cyc);
                        end
                        last_rgb = exp;
                    end
                end else begin
                    if (valid_exp_cur && exp_q.size() != 0) void'(exp_q.pop_front());
                    checks++;
                    if (rgb_data !== last_rgb) begin
                        errors++;
                        $display("FAIL rgb_hold: got %h expected %h (cycle %0d)", rgb_data, last_rgb, cyc);
                    end
                end
            end
        end
    end

    initial begin
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        mon_en = 1'b1;

        run_line("basic", 26, -1, -1, -1, -1, -1, -1,
                 64'h1110, 64'h11_0000, 64'h20_0000);
        run_line("overrun", 26, 6, -1, -1, -1, -1, -1,
                 64'h1110, 64'h11_0000, 64'h20_0000);
        run_line("abort", 26, -1, 10, -1, -1, -1, -1,
                 64'h110, 64'h0, 64'h0);
        run_line("reset_mid", 40, 12, -1, 9, -1, -1, -1,
                 64'h0111_0110, 64'h1_1000_0000, 64'h2_0000_0000);
`ifdef FIFO_EMPTY_GUARD_EN
        run_line("empty_stall", 30, -1, -1, -1, 7, 9, -1,
                 64'h4410, 64'h44_0000, 64'h80_0000);
`else
        run_line("underrun", 26, -1, -1, -1, -1, -1, 16,
                 64'h1110, 64'h11_0000, 64'h20_0000);
`endif

        // line_start together with frame_sync in idle: frame_sync wins, no overrun
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 199) == 0);
        end

        for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk_200MHz);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d words left expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
